// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: FSM encoding and BCD digit constants.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;

    localparam int             BCD_W   = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/stopwatch_ctrl_btn_cond.sv
// Button conditioner: 2-flop synchronizer, optional debounce, rising-edge press pulse.
// Debounce stage is present only when STOPWATCH_DEBOUNCE_EN is defined.
module btn_cond
`ifdef STOPWATCH_DEBOUNCE_EN
#(
    parameter int DB_CYCLES = 500000
)
`endif
(
    input  logic clk,
    input  logic clr,
    input  logic raw,
    output logic press
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_d;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] db_cnt;

    // Accepted level flips only after DB_CYCLES consecutive samples that disagree with it.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            level  <= 1'b0;
            db_cnt <= '0;
        end else if (sync2 == level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            level  <= sync2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end
`else
    assign level = sync2;
`endif

    assign press = level & ~level_d;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap/reset controller with 1 Hz prescaler and 00-99 BCD seconds count.
// Optional button debounce is enabled by defining STOPWATCH_DEBOUNCE_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = 50000000,
    parameter int DB_CYCLES = 500000
) (
    input  logic             clk_50MHz,
    input  logic             clr,
    input  logic             btn_ss,
    input  logic             btn_lr,
    output logic             run,
    output logic             lap,
    output logic [BCD_W-1:0] disp_tens,
    output logic [BCD_W-1:0] disp_ones,
    output logic             tick,
    output logic             cn
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    if (TICK_DIV < 1 || DB_CYCLES < 1) begin : g_param_check
        $error("stopwatch_ctrl: TICK_DIV and DB_CYCLES must be at least 1");
    end

    state_t           state;
    state_t           state_nxt;
    logic             ss_p;
    logic             lr_p;
    logic             capture;
    logic             clear_cnt;
    logic             counting;
    logic             step;
    logic [PW-1:0]    presc;
    logic [BCD_W-1:0] cnt_tens;
    logic [BCD_W-1:0] cnt_ones;
    logic [BCD_W-1:0] lap_tens;
    logic [BCD_W-1:0] lap_ones;

`ifdef STOPWATCH_DEBOUNCE_EN
    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_cond_ss (.clk(clk_50MHz), .clr(clr), .raw(btn_ss), .press(ss_p));
    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_cond_lr (.clk(clk_50MHz), .clr(clr), .raw(btn_lr), .press(lr_p));
`else
    btn_cond u_cond_ss (.clk(clk_50MHz), .clr(clr), .raw(btn_ss), .press(ss_p));
    btn_cond u_cond_lr (.clk(clk_50MHz), .clr(clr), .raw(btn_lr), .press(lr_p));
`endif

    // Start/stop has priority: a simultaneous lap/reset press is dropped.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        clear_cnt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ss_p) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (ss_p) begin
                    state_nxt = ST_PAUSE;
                end else if (lr_p) begin
                    state_nxt = ST_LAP;
                    capture   = 1'b1;
                end
            end
            ST_LAP: begin
                if (ss_p)      state_nxt = ST_PAUSE;
                else if (lr_p) state_nxt = ST_RUN;
            end
            ST_PAUSE: begin
                if (ss_p) begin
                    state_nxt = ST_RUN;
                end else if (lr_p) begin
                    state_nxt = ST_IDLE;
                    clear_cnt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign counting = (state == ST_RUN) || (state == ST_LAP);
    assign step     = counting && (presc == PRESC_LAST);

    always_ff @(posedge clk_50MHz or posedge clr) begin
        if (clr) begin
            state <= ST_IDLE;
            presc <= '0;
            tick  <= 1'b0;
            cn    <= 1'b0;
        end else begin
            state <= state_nxt;
            tick  <= step;
            cn    <= step && (cnt_tens == BCD_MAX) && (cnt_ones == BCD_MAX);
            if (state == ST_IDLE || clear_cnt) begin
                presc <= '0;
            end else if (counting) begin
                presc <= step ? '0 : presc + 1'b1;
            end
        end
    end

    // Two-digit BCD count; the lap latch samples the pre-increment value.
    always_ff @(posedge clk_50MHz or posedge clr) begin
        if (clr) begin
            cnt_tens <= '0;
            cnt_ones <= '0;
            lap_tens <= '0;
            lap_ones <= '0;
        end else begin
            if (clear_cnt) begin
                cnt_tens <= '0;
                cnt_ones <= '0;
            end else if (step) begin
                if (cnt_ones == BCD_MAX) begin
                    cnt_ones <= '0;
                    cnt_tens <= (cnt_tens == BCD_MAX) ? '0 : cnt_tens + 1'b1;
                end else begin
                    cnt_ones <= cnt_ones + 1'b1;
                end
            end
            if (capture) begin
                lap_tens <= cnt_tens;
                lap_ones <= cnt_ones;
            end
        end
    end

    assign run       = counting;
    assign lap       = (state == ST_LAP);
    assign disp_tens = lap ? lap_tens : cnt_tens;
    assign disp_ones = lap ? lap_ones : cnt_ones;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random button activity
// against a seconds-level reference model. Honours STOPWATCH_DEBOUNCE_EN when defined.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int DB_CYCLES = 3;
`ifdef STOPWATCH_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif
    localparam int HOLD = DEB ? DB_CYCLES + 1 : 1;
    localparam int HW   = 16;

    logic       clk_50MHz = 1'b0;
    logic       clr       = 1'b1;
    logic       btn_ss    = 1'b0;
    logic       btn_lr    = 1'b0;
    logic       run;
    logic       lap;
    logic [3:0] disp_tens;
    logic [3:0] disp_ones;
    logic       tick;
    logic       cn;

    always #10 clk_50MHz = ~clk_50MHz;

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES)) dut (
        .clk_50MHz(clk_50MHz),
        .clr      (clr),
        .btn_ss   (btn_ss),
        .btn_lr   (btn_lr),
        .run      (run),
        .lap      (lap),
        .disp_tens(disp_tens),
        .disp_ones(disp_ones),
        .tick     (tick),
        .cn       (cn)
    );

    int checks   = 0;
    int failures = 0;
    int edge_no  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: mode, elapsed seconds, cycles into the current second.
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_LAP} mode_e;
    mode_e m_mode;
    int    m_secs;
    int    m_lap_secs;
    int    m_phase;
    bit    m_tick;
    bit    m_cn;
    bit    hist [2][HW];   // hist[b][j] = raw level sampled j edges ago
    bit    acc  [2];
    bit    acc_d[2];

    function automatic void model_reset();
        m_mode = M_IDLE; m_secs = 0; m_lap_secs = 0; m_phase = 0;
        m_tick = 1'b0; m_cn = 1'b0;
        for (int b = 0; b < 2; b++) begin
            acc[b] = 1'b0; acc_d[b] = 1'b0;
            for (int j = 0; j < HW; j++) hist[b][j] = 1'b0;
        end
    endfunction

    task automatic press_seen(input int b, output bit p);
        bit flip;
        if (!DEB) begin
            p = hist[b][2] & ~hist[b][3];
        end else begin
            p = acc[b] & ~acc_d[b];
            acc_d[b] = acc[b];
            flip = 1'b1;
            for (int j = 2; j <= DB_CYCLES + 1; j++)
                if (hist[b][j] == acc[b]) flip = 1'b0;
            if (flip) acc[b] = ~acc[b];
        end
    endtask

    task automatic model_edge();
        bit ss;
        bit lr;
        int old_secs;
        for (int b = 0; b < 2; b++)
            for (int j = HW - 1; j > 0; j--) hist[b][j] = hist[b][j-1];
        hist[0][0] = btn_ss;
        hist[1][0] = btn_lr;
        press_seen(0, ss);
        press_seen(1, lr);
        old_secs = m_secs;
        m_tick = 1'b0;
        m_cn   = 1'b0;
        if (m_mode == M_RUN || m_mode == M_LAP) begin
            m_phase++;
            if (m_phase == TICK_DIV) begin
                m_phase = 0;
                m_tick  = 1'b1;
                m_secs  = (m_secs + 1) % 100;
                m_cn    = (m_secs == 0);
            end
        end else if (m_mode == M_IDLE) begin
            m_phase = 0;
        end
        if (ss) begin
            m_mode = (m_mode == M_RUN || m_mode == M_LAP) ? M_PAUSE : M_RUN;
        end else if (lr) begin
            case (m_mode)
                M_RUN:   begin m_mode = M_LAP; m_lap_secs = old_secs; end
                M_LAP:   m_mode = M_RUN;
                M_PAUSE: begin m_mode = M_IDLE; m_secs = 0; m_phase = 0; end
                default: ;
            endcase
        end
    endtask

    function automatic logic [11:0] expected();
        int shown;
        shown = (m_mode == M_LAP) ? m_lap_secs : m_secs;
        return {(m_mode == M_RUN || m_mode == M_LAP), (m_mode == M_LAP),
                4'(shown / 10), 4'(shown % 10), m_tick, m_cn};
    endfunction

    function automatic logic [11:0] observed();
        return {run, lap, disp_tens, disp_ones, tick, cn};
    endfunction

    task automatic step();
        @(posedge clk_50MHz);
        edge_no++;
        model_edge();
        #1;
        check($sformatf("cycle%0d", edge_no), 32'(observed()), 32'(expected()));
    endtask

    task automatic press(input bit s, input bit l, input int hold);
        btn_ss = s; btn_lr = l;
        repeat (hold) step();
        btn_ss = 1'b0; btn_lr = 1'b0;
        repeat (10) step();
    endtask

    task automatic wait_disp(input logic [7:0] target, input int budget, input string tag);
        int n = 0;
        while ({disp_tens, disp_ones} != target && n < budget) begin
            step();
            n++;
        end
        check({tag, "_reached"}, 32'({disp_tens, disp_ones}), 32'(target));
    endtask

    task automatic async_clear(input string tag);
        #5 clr = 1'b1;
        #1 check(tag, 32'(observed()), 32'h0);
        #24 clr = 1'b0;
        model_reset();
    endtask

    initial begin
        int n;
        int ticks;
        model_reset();

        // Power-up reset, released mid-cycle
        repeat (3) @(posedge clk_50MHz);
        #5 clr = 1'b0;
        check("reset_out", 32'(observed()), 32'h0);
        ticks = 0;
        repeat (100) begin
            step();
            ticks += tick;
        end
        check("idle_ticks", 32'(ticks), 32'd0);

        // Start and count past the first BCD carry
        press(1'b1, 1'b0, HOLD);
        check("run_after_start", 32'(run), 32'd1);
        wait_disp(8'h10, 200, "count10");

        // Wrap at 99 -> 00 with carry pulse
        n = 0;
        while (cn !== 1'b1 && n < 600) begin step(); n++; end
        check("wrap_cn_disp", 32'({cn, disp_tens, disp_ones}), 32'h100);
        step();
        check("wrap_cn_once", 32'(cn), 32'd0);

        // Lap freeze while counting continues underneath
        wait_disp(8'h05, 200, "count05");
        press(1'b0, 1'b1, HOLD);
        check("lap_mode", 32'({run, lap}), 32'b11);
        repeat (12) step();
        press(1'b0, 1'b1, HOLD);
        check("lap_exit", 32'({run, lap}), 32'b10);

        // Pause hold, then back to idle
        press(1'b1, 1'b0, HOLD);
        repeat (50) step();
        check("paused", 32'({run, lap, tick}), 32'h0);
        press(1'b0, 1'b1, HOLD);
        check("idle_cleared", 32'(observed()), 32'h0);

        // Simultaneous buttons in RUN: start/stop wins
        press(1'b1, 1'b0, HOLD);
        repeat (9) step();
        press(1'b1, 1'b1, HOLD);
        check("both_to_pause", 32'({run, lap}), 32'b00);

        // Asynchronous clear while running
        press(1'b1, 1'b0, HOLD);
        repeat (13) step();
        async_clear("clr_midop");
        repeat (5) step();

`ifdef STOPWATCH_DEBOUNCE_EN
        // Short glitch rejected, proper press accepted
        press(1'b1, 1'b0, 2);
        check("glitch_ignored", 32'(run), 32'd0);
        btn_ss = 1'b1;
        repeat (5) step();
        check("deb_not_yet", 32'(run), 32'd0);
        step();
        check("deb_run_edge6", 32'(run), 32'd1);
        btn_ss = 1'b0;
        repeat (10) step();
`endif

        // Random button activity
        repeat (1500) begin
            if ($urandom_range(0, 7) == 0) btn_ss = ~btn_ss;
            if ($urandom_range(0, 7) == 0) btn_lr = ~btn_lr;
            step();
        end
        btn_ss = 1'b0; btn_lr = 1'b0;
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
